// File: rtl/mem_request_arbiter_pkg.sv
// Shared types for the CPU-side memory request arbiter and the SPI memory controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_request_arbiter_pkg;

  typedef enum logic [1:0] {
    TYPE_IMEM_READ  = 2'd0,
    TYPE_DMEM_READ  = 2'd1,
    TYPE_DMEM_WRITE = 2'd2
  } mem_type_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_IMEM = 1'b0,
    PORT_DMEM = 1'b1
  } port_t;

endpackage

// File: rtl/mem_request_arbiter_if.sv
// Bundle of the fetch port, data port and controller-side request/response signals.
// Latency: n/a (wiring only).
// Backpressure: requests are levels held until ack; controller stalls via mem_busy_in.
interface mem_request_arbiter_if;
  import mem_request_arbiter_pkg::*;

  // CPU instruction-fetch port
  logic        imem_req_in;
  logic [15:0] imem_addr_in;
  logic [15:0] imem_data_out;
  logic        imem_ack_out;
  // CPU data load/store port
  logic        dmem_req_in;
  logic        dmem_we_in;
  logic [15:0] dmem_addr_in;
  logic [7:0]  dmem_wdata_in;
  logic [7:0]  dmem_rdata_out;
  logic        dmem_ack_out;
  // SPI memory controller request/response
  logic [15:0] mem_addr_out;
  logic        mem_addr_valid_out;
  mem_type_t   mem_type_out;
  logic [7:0]  mem_wdata_out;
  logic        mem_busy_in;
  logic [15:0] flash_data_in;
  logic        flash_data_valid_in;
  logic [7:0]  psram_data_in;
  logic        psram_data_valid_in;

  // Arbiter side: serves both CPU ports and drives the controller.
  modport master (
    input  imem_req_in, imem_addr_in, dmem_req_in, dmem_we_in, dmem_addr_in, dmem_wdata_in,
           mem_busy_in, flash_data_in, flash_data_valid_in, psram_data_in, psram_data_valid_in,
    output imem_data_out, imem_ack_out, dmem_rdata_out, dmem_ack_out,
           mem_addr_out, mem_addr_valid_out, mem_type_out, mem_wdata_out
  );

  // Environment side: CPU ports plus the memory controller.
  modport slave (
    output imem_req_in, imem_addr_in, dmem_req_in, dmem_we_in, dmem_addr_in, dmem_wdata_in,
           mem_busy_in, flash_data_in, flash_data_valid_in, psram_data_in, psram_data_valid_in,
    input  imem_data_out, imem_ack_out, dmem_rdata_out, dmem_ack_out,
           mem_addr_out, mem_addr_valid_out, mem_type_out, mem_wdata_out
  );

endinterface

// File: rtl/mem_request_arbiter.sv
// Merges CPU fetch and data ports onto one SPI controller request; one-word fetch hit register.
// Latency: hit ack 1 cycle after req; SPI grant 1 cycle after req, ack 1 cycle after data/busy-drop.
// Backpressure: no grant while mem_busy_in is high; requests stay pending (level) until acked.
module mem_request_arbiter
  import mem_request_arbiter_pkg::*;
#(
  parameter bit DMEM_PRIORITY = 1'b1,
  parameter bit HIT_REG_EN    = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  mem_request_arbiter_if.master bus
);

  arb_state_t  state;
  arb_state_t  state_nxt;
  port_t       last_grant;
  logic        hit_valid;
  logic [15:0] hit_addr;
  logic [15:0] hit_data;

  logic [15:0] imem_word_addr;
  logic        imem_pend;
  logic        dmem_pend;
  logic        hit_now;
  logic        grant_imem;
  logic        grant_dmem;
  logic        issue_done;
  logic        iack_now;
  logic        dack_rd_now;
  logic        dack_wr_now;

  // Flash is word addressed: the low byte-address bit never reaches the controller.
  assign imem_word_addr = bus.imem_addr_in & 16'hFFFE;

  // A request still high during its own ack cycle is the tail of the request just served.
  assign imem_pend = bus.imem_req_in && !bus.imem_ack_out;
  assign dmem_pend = bus.dmem_req_in && !bus.dmem_ack_out;

  // State register
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state plus one-cycle control strobes for the datapath
  always_comb begin
    state_nxt   = state;
    hit_now     = 1'b0;
    grant_imem  = 1'b0;
    grant_dmem  = 1'b0;
    issue_done  = 1'b0;
    iack_now    = 1'b0;
    dack_rd_now = 1'b0;
    dack_wr_now = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Hit check is independent of the controller, so it may overlap a dmem grant.
        hit_now = HIT_REG_EN && imem_pend && hit_valid && (imem_word_addr == hit_addr);
        if (!bus.mem_busy_in) begin
          if (dmem_pend && (!imem_pend || hit_now || DMEM_PRIORITY || (last_grant == PORT_IMEM)))
            grant_dmem = 1'b1;
          else if (imem_pend && !hit_now)
            grant_imem = 1'b1;
        end
        if (grant_dmem || grant_imem) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (bus.mem_busy_in) begin
          issue_done = 1'b1;
          state_nxt  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        unique case (bus.mem_type_out)
          TYPE_IMEM_READ:  iack_now    = bus.flash_data_valid_in;
          TYPE_DMEM_READ:  dack_rd_now = bus.psram_data_valid_in;
          TYPE_DMEM_WRITE: dack_wr_now = !bus.mem_busy_in;
          default:         state_nxt   = ST_IDLE;
        endcase
        if (iack_now || dack_rd_now || dack_wr_now) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs, grant bookkeeping and the fetch hit register
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      bus.imem_data_out      <= '0;
      bus.imem_ack_out       <= 1'b0;
      bus.dmem_rdata_out     <= '0;
      bus.dmem_ack_out       <= 1'b0;
      bus.mem_addr_out       <= '0;
      bus.mem_addr_valid_out <= 1'b0;
      bus.mem_type_out       <= TYPE_IMEM_READ;
      bus.mem_wdata_out      <= '0;
      last_grant             <= PORT_IMEM;
      hit_valid              <= 1'b0;
      hit_addr               <= '0;
      hit_data               <= '0;
    end else begin
      bus.imem_ack_out <= hit_now || iack_now;
      bus.dmem_ack_out <= dack_rd_now || dack_wr_now;

      if (hit_now) bus.imem_data_out <= hit_data;
      if (iack_now) begin
        bus.imem_data_out <= bus.flash_data_in;
        if (HIT_REG_EN) begin
          hit_valid <= 1'b1;
          hit_addr  <= bus.mem_addr_out;
          hit_data  <= bus.flash_data_in;
        end
      end
      if (dack_rd_now) bus.dmem_rdata_out <= bus.psram_data_in;

      if (grant_dmem) begin
        bus.mem_addr_out       <= bus.dmem_addr_in;
        bus.mem_type_out       <= bus.dmem_we_in ? TYPE_DMEM_WRITE : TYPE_DMEM_READ;
        bus.mem_wdata_out      <= bus.dmem_wdata_in;
        bus.mem_addr_valid_out <= 1'b1;
        last_grant             <= PORT_DMEM;
      end else if (grant_imem) begin
        bus.mem_addr_out       <= imem_word_addr;
        bus.mem_type_out       <= TYPE_IMEM_READ;
        bus.mem_addr_valid_out <= 1'b1;
        last_grant             <= PORT_IMEM;
      end

      // Controller has accepted the request once it reports busy.
      if (issue_done) bus.mem_addr_valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Scoreboard bench: directed fetch/load/store sequences against a behavioural SPI controller.
// Latency: controller model answers reads 3 cycles after accepting, drops busy 3 cycles later.
// Backpressure: controller model holds busy for the whole transaction.
module tb_mem_request_arbiter;
  import mem_request_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  mem_request_arbiter_if bus ();
  mem_request_arbiter_if rbus ();

  mem_request_arbiter #(.DMEM_PRIORITY(1'b1), .HIT_REG_EN(1'b1)) u_dut (
    .clk_in(clk), .reset_in(rst), .bus(bus)
  );
  mem_request_arbiter #(.DMEM_PRIORITY(1'b0), .HIT_REG_EN(1'b0)) u_rr (
    .clk_in(clk), .reset_in(rst), .bus(rbus)
  );

  typedef struct packed {
    logic [15:0] addr;
    mem_type_t   kind;
    logic [7:0]  wdata;
  } exp_grant_t;

  typedef struct packed {
    logic        is_dmem;
    logic        chk;
    logic [15:0] data;
  } exp_ack_t;

  exp_grant_t grant_q[$];
  exp_grant_t rr_q[$];
  exp_ack_t   ack_q[$];

  // Memory contents served by the controller model
  function automatic logic [15:0] flash_word(input logic [15:0] a);
    if (a == 16'h0012) return 16'hA55A;
    return a ^ 16'h5A00;
  endfunction

  function automatic logic [7:0] psram_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void exp_grant(input logic [15:0] a, input mem_type_t k, input logic [7:0] w);
    exp_grant_t g;
    g.addr = a; g.kind = k; g.wdata = w;
    grant_q.push_back(g);
  endfunction

  function automatic void exp_rr(input logic [15:0] a, input mem_type_t k);
    exp_grant_t g;
    g.addr = a; g.kind = k; g.wdata = 8'h00;
    rr_q.push_back(g);
  endfunction

  function automatic void exp_ack(input logic is_d, input logic chk, input logic [15:0] d);
    exp_ack_t e;
    e.is_dmem = is_d; e.chk = chk; e.data = d;
    ack_q.push_back(e);
  endfunction

  // Controller model for the main instance
  logic [2:0]  m_cnt;
  mem_type_t   m_kind;
  logic [15:0] m_addr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_busy_in <= 1'b0; bus.flash_data_valid_in <= 1'b0; bus.psram_data_valid_in <= 1'b0;
      bus.flash_data_in <= '0; bus.psram_data_in <= '0;
      m_cnt <= '0; m_kind <= TYPE_IMEM_READ; m_addr <= '0;
    end else begin
      bus.flash_data_valid_in <= 1'b0;
      bus.psram_data_valid_in <= 1'b0;
      if (!bus.mem_busy_in && bus.mem_addr_valid_out) begin
        bus.mem_busy_in <= 1'b1; m_cnt <= '0;
        m_kind <= bus.mem_type_out; m_addr <= bus.mem_addr_out;
      end else if (bus.mem_busy_in) begin
        m_cnt <= m_cnt + 3'd1;
        if (m_cnt == 3'd2 && m_kind == TYPE_IMEM_READ) begin
          bus.flash_data_valid_in <= 1'b1; bus.flash_data_in <= flash_word(m_addr);
        end
        if (m_cnt == 3'd2 && m_kind == TYPE_DMEM_READ) begin
          bus.psram_data_valid_in <= 1'b1; bus.psram_data_in <= psram_byte(m_addr);
        end
        if (m_cnt == 3'd5) bus.mem_busy_in <= 1'b0;
      end
    end
  end

  // Controller model for the round-robin instance
  logic [2:0]  r_cnt;
  mem_type_t   r_kind;
  logic [15:0] r_addr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rbus.mem_busy_in <= 1'b0; rbus.flash_data_valid_in <= 1'b0; rbus.psram_data_valid_in <= 1'b0;
      rbus.flash_data_in <= '0; rbus.psram_data_in <= '0;
      r_cnt <= '0; r_kind <= TYPE_IMEM_READ; r_addr <= '0;
    end else begin
      rbus.flash_data_valid_in <= 1'b0;
      rbus.psram_data_valid_in <= 1'b0;
      if (!rbus.mem_busy_in && rbus.mem_addr_valid_out) begin
        rbus.mem_busy_in <= 1'b1; r_cnt <= '0;
        r_kind <= rbus.mem_type_out; r_addr <= rbus.mem_addr_out;
      end else if (rbus.mem_busy_in) begin
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt == 3'd2 && r_kind == TYPE_IMEM_READ) begin
          rbus.flash_data_valid_in <= 1'b1; rbus.flash_data_in <= flash_word(r_addr);
        end
        if (r_cnt == 3'd2 && r_kind == TYPE_DMEM_READ) begin
          rbus.psram_data_valid_in <= 1'b1; rbus.psram_data_in <= psram_byte(r_addr);
        end
        if (r_cnt == 3'd5) rbus.mem_busy_in <= 1'b0;
      end
    end
  end

  // Grant monitor (main): every new request to the controller must match the next expected grant
  logic g_prev_valid = 1'b0;
  logic g_prev_busy  = 1'b0;
  always @(negedge clk) begin
    exp_grant_t g;
    if (bus.mem_addr_valid_out === 1'b1 && !g_prev_valid) begin
      if (grant_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_grant: addr=0x%0h type=%0d, none expected", bus.mem_addr_out, bus.mem_type_out);
      end else begin
        g = grant_q.pop_front();
        check("grant_addr", 32'(bus.mem_addr_out), 32'(g.addr));
        check("grant_type", 32'(bus.mem_type_out), 32'(g.kind));
        if (g.kind == TYPE_DMEM_WRITE) check("grant_wdata", 32'(bus.mem_wdata_out), 32'(g.wdata));
        check("grant_while_idle_ctrl", 32'(bus.mem_busy_in), 32'd0);
      end
    end
    if (g_prev_busy && bus.mem_busy_in === 1'b0)
      check("valid_one_window", 32'(bus.mem_addr_valid_out), 32'd0);
    g_prev_valid = (bus.mem_addr_valid_out === 1'b1);
    g_prev_busy  = (bus.mem_busy_in === 1'b1);
  end

  // Grant monitor (round-robin instance)
  logic r_prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_grant_t g;
    if (rbus.mem_addr_valid_out === 1'b1 && !r_prev_valid) begin
      if (rr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rr_unexpected_grant: addr=0x%0h type=%0d, none expected", rbus.mem_addr_out, rbus.mem_type_out);
      end else begin
        g = rr_q.pop_front();
        check("rr_grant_addr", 32'(rbus.mem_addr_out), 32'(g.addr));
        check("rr_grant_type", 32'(rbus.mem_type_out), 32'(g.kind));
      end
    end
    r_prev_valid = (rbus.mem_addr_valid_out === 1'b1);
  end

  task automatic pop_ack(input logic is_d, input logic [15:0] data);
    exp_ack_t e;
    if (ack_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_ack: port=%0d data=0x%0h, none expected", is_d, data);
      return;
    end
    e = ack_q.pop_front();
    check("ack_port", 32'(is_d), 32'(e.is_dmem));
    if (e.chk) check("ack_data", 32'(data), 32'(e.data));
  endtask

  // Ack monitor (main): each ack cycle consumes exactly one expected response
  always @(negedge clk) begin
    if (bus.imem_ack_out === 1'b1) pop_ack(1'b0, bus.imem_data_out);
    if (bus.dmem_ack_out === 1'b1) pop_ack(1'b1, {8'h00, bus.dmem_rdata_out});
  end

  // Waits for an ack on the main instance; b1/b2 are busy one and two samples before the ack.
  task automatic wait_ack(input logic is_d, output int cyc, output logic b1, output logic b2);
    logic seen;
    cyc = 0; b1 = 1'b0; b2 = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      seen = is_d ? (bus.dmem_ack_out === 1'b1) : (bus.imem_ack_out === 1'b1);
      if (seen) break;
      if (cyc >= 60) begin
        checks++; failures++;
        $display("FAIL ack_timeout: port=%0d no ack after %0d cycles", is_d, cyc);
        break;
      end
      b2 = b1;
      b1 = (bus.mem_busy_in === 1'b1);
    end
  endtask

  task automatic imem_fetch(input logic [15:0] a, output int cyc);
    logic b1, b2;
    bus.imem_addr_in = a;
    bus.imem_req_in  = 1'b1;
    wait_ack(1'b0, cyc, b1, b2);
    bus.imem_req_in  = 1'b0;
  endtask

  task automatic dmem_op(input logic [15:0] a, input logic we, input logic [7:0] wd,
                         output logic b1, output logic b2);
    int cyc;
    bus.dmem_addr_in  = a;
    bus.dmem_we_in    = we;
    bus.dmem_wdata_in = wd;
    bus.dmem_req_in   = 1'b1;
    wait_ack(1'b1, cyc, b1, b2);
    bus.dmem_req_in   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   cyc, dn, icnt, rcyc;
    logic b1, b2;

    bus.imem_req_in = 1'b0; bus.imem_addr_in = '0;
    bus.dmem_req_in = 1'b0; bus.dmem_we_in = 1'b0; bus.dmem_addr_in = '0; bus.dmem_wdata_in = '0;
    rbus.imem_req_in = 1'b0; rbus.imem_addr_in = '0;
    rbus.dmem_req_in = 1'b0; rbus.dmem_we_in = 1'b0; rbus.dmem_addr_in = '0; rbus.dmem_wdata_in = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_imem_ack",  32'(bus.imem_ack_out), 32'd0);
    check("rst_dmem_ack",  32'(bus.dmem_ack_out), 32'd0);
    check("rst_valid",     32'(bus.mem_addr_valid_out), 32'd0);
    check("rst_addr",      32'(bus.mem_addr_out), 32'd0);
    check("rst_type",      32'(bus.mem_type_out), 32'(TYPE_IMEM_READ));
    check("rst_imem_data", 32'(bus.imem_data_out), 32'd0);

    // 1: cold fetch of an odd byte address goes to SPI at the even word address
    exp_grant(16'h0012, TYPE_IMEM_READ, 8'h00);
    exp_ack(1'b0, 1'b1, 16'hA55A);
    imem_fetch(16'h0013, cyc);
    repeat (2) @(negedge clk);

    // 2: repeat fetch of the same word is served from the hit register next cycle
    exp_ack(1'b0, 1'b1, 16'hA55A);
    imem_fetch(16'h0012, cyc);
    check("hit_latency", 32'(cyc), 32'd1);
    check("hit_no_spi", 32'(bus.mem_addr_valid_out), 32'd0);
    repeat (2) @(negedge clk);

    // 3: simultaneous fetch and data read, data port has priority
    exp_grant(16'h0100, TYPE_DMEM_READ, 8'h00);
    exp_grant(16'h0100, TYPE_IMEM_READ, 8'h00);
    exp_ack(1'b1, 1'b1, 16'h003D);
    exp_ack(1'b0, 1'b1, 16'h5B00);
    fork
      imem_fetch(16'h0100, cyc);
      dmem_op(16'h0100, 1'b0, 8'h00, b1, b2);
    join
    repeat (2) @(negedge clk);

    // 4: data write, ack exactly one cycle after busy falls
    exp_grant(16'h0200, TYPE_DMEM_WRITE, 8'h3C);
    exp_ack(1'b1, 1'b0, 16'h0000);
    dmem_op(16'h0200, 1'b1, 8'h3C, b1, b2);
    check("wr_ack_after_busy_fall", {30'd0, b2, b1}, 32'b10);
    repeat (2) @(negedge clk);

    // 5: reset during WAIT clears outputs at once, suppresses the ack and forgets the hit
    exp_grant(16'h0040, TYPE_IMEM_READ, 8'h00);
    bus.imem_addr_in = 16'h0040;
    bus.imem_req_in  = 1'b1;
    rcyc = 0;
    while (!(bus.mem_busy_in === 1'b1 && bus.mem_addr_valid_out === 1'b0) && rcyc < 30) begin
      @(negedge clk);
      rcyc++;
    end
    if (rcyc >= 30) begin
      checks++; failures++;
      $display("FAIL wait_state_timeout: arbiter never reached WAIT after %0d cycles", rcyc);
    end
    #2 rst = 1'b1;
    #1;
    check("arst_imem_data", 32'(bus.imem_data_out), 32'd0);
    check("arst_dmem_data", 32'(bus.dmem_rdata_out), 32'd0);
    check("arst_addr",      32'(bus.mem_addr_out), 32'd0);
    check("arst_wdata",     32'(bus.mem_wdata_out), 32'd0);
    check("arst_valid",     32'(bus.mem_addr_valid_out), 32'd0);
    check("arst_type",      32'(bus.mem_type_out), 32'(TYPE_IMEM_READ));
    bus.imem_req_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    exp_grant(16'h0012, TYPE_IMEM_READ, 8'h00);
    exp_ack(1'b0, 1'b1, 16'hA55A);
    imem_fetch(16'h0012, cyc);
    check("post_reset_fetch_is_miss", 32'(cyc > 1), 32'd1);
    repeat (2) @(negedge clk);

    // 6: back-to-back data reads with req held high; second issue waits for busy to drop
    exp_grant(16'h0104, TYPE_DMEM_READ, 8'h00);
    exp_grant(16'h0105, TYPE_DMEM_READ, 8'h00);
    exp_ack(1'b1, 1'b1, 16'h0039);
    exp_ack(1'b1, 1'b1, 16'h0038);
    bus.dmem_addr_in = 16'h0104;
    bus.dmem_we_in   = 1'b0;
    bus.dmem_req_in  = 1'b1;
    wait_ack(1'b1, cyc, b1, b2);
    bus.dmem_addr_in = 16'h0105;
    wait_ack(1'b1, cyc, b1, b2);
    bus.dmem_req_in  = 1'b0;
    repeat (10) @(negedge clk);

    // Round-robin instance: both ports held requesting, grants alternate starting with dmem
    for (int k = 0; k < 3; k++) begin
      exp_rr(16'h0100, TYPE_DMEM_READ);
      exp_rr(16'h0300, TYPE_IMEM_READ);
    end
    rbus.dmem_addr_in = 16'h0100;
    rbus.imem_addr_in = 16'h0300;
    rbus.dmem_req_in  = 1'b1;
    rbus.imem_req_in  = 1'b1;
    dn = 0; icnt = 0; rcyc = 0;
    while ((dn < 3 || icnt < 3) && rcyc < 300) begin
      @(negedge clk);
      rcyc++;
      if (rbus.dmem_ack_out === 1'b1) begin
        dn++;
        check("rr_dmem_data", 32'(rbus.dmem_rdata_out), 32'h3D);
        if (dn == 3) rbus.dmem_req_in = 1'b0;
      end
      if (rbus.imem_ack_out === 1'b1) begin
        icnt++;
        check("rr_imem_data", 32'(rbus.imem_data_out), 32'h5900);
        if (icnt == 3) rbus.imem_req_in = 1'b0;
      end
    end
    if (rcyc >= 300) begin
      checks++; failures++;
      $display("FAIL rr_timeout: dmem acks=%0d imem acks=%0d after %0d cycles", dn, icnt, rcyc);
    end
    repeat (10) @(negedge clk);

    check("grant_q_empty", 32'(grant_q.size()), 32'd0);
    check("ack_q_empty",   32'(ack_q.size()), 32'd0);
    check("rr_q_empty",    32'(rr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
